// File: rtl/register_dump_unit.sv
// Walks the register bank from address 0 upward and serialises every register
// MSB-first into bytes for the UART transmitter, one byte per tx_start/tx_done handshake.
module register_dump_unit #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] dump_reg_addr,
  input  logic [DATA_W-1:0] dump_reg_data,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  input  logic              tx_done,
  output logic              busy,
  output logic              done
);

  localparam int NBYTES = DATA_W / 8;
  localparam int BIDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);
  localparam logic [BIDX_W-1:0] LAST_BYTE = BIDX_W'(NBYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_SEND,
    S_WAIT,
    S_FIN
  } state_t;

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic [BIDX_W-1:0]   byte_idx_reg, byte_idx_next;
  logic [DATA_W-1:0]   word_reg, word_next;
  logic [7:0]          tx_data_reg, tx_data_next;
  logic [7:0]          word_lanes [NBYTES];

  // Byte lanes of the word that will be held after this edge; lane 0 is the MSB.
  genvar gi;
  generate
    for (gi = 0; gi < NBYTES; gi++) begin : g_lane
      assign word_lanes[gi] = word_next[DATA_W-1-8*gi -: 8];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= S_IDLE;
      addr_reg     <= '0;
      byte_idx_reg <= '0;
      word_reg     <= '0;
      tx_data_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      addr_reg     <= addr_next;
      byte_idx_reg <= byte_idx_next;
      word_reg     <= word_next;
      tx_data_reg  <= tx_data_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    addr_next     = addr_reg;
    byte_idx_next = byte_idx_reg;
    word_next     = word_reg;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          state_next    = S_LATCH;
          addr_next     = '0;
          byte_idx_next = '0;
        end
      end
      S_LATCH: begin
        // The only point where register contents are sampled.
        word_next  = dump_reg_data;
        state_next = S_SEND;
      end
      S_SEND: begin
        state_next = S_WAIT;
      end
      S_WAIT: begin
        if (tx_done) begin
          if (byte_idx_reg < LAST_BYTE) begin
            byte_idx_next = byte_idx_reg + BIDX_W'(1);
            state_next    = S_SEND;
          end else if (addr_reg < LAST_ADDR) begin
            addr_next     = addr_reg + ADDR_W'(1);
            byte_idx_next = '0;
            state_next    = S_LATCH;
          end else begin
            state_next = S_FIN;
          end
        end
      end
      S_FIN: begin
        state_next = S_IDLE;
        addr_next  = '0;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // tx_data only changes on entry to SEND, so it is stable for the whole handshake.
  always_comb begin
    tx_data_next = tx_data_reg;
    if (state_next == S_SEND) begin
      tx_data_next = word_lanes[byte_idx_next];
    end
  end

  assign dump_reg_addr = addr_reg;
  assign tx_data       = tx_data_reg;
  assign tx_start      = (state_reg == S_SEND);
  assign busy          = (state_reg != S_IDLE);
  assign done          = (state_reg == S_FIN);

endmodule
